// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1306-class OLED serial write path:
// FSM state encoding, DATA word layout and word width.
package oled_pkg;

  localparam int OLED_WORD_W   = 10;
  localparam int OLED_BYTE_MSB = 7;
  localparam int OLED_DC_BIT   = 8;
  localparam int OLED_HOLD_BIT = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4
  } oled_state_e;

endpackage

// File: rtl/oled_clk_tick.sv
// Half-period down-counter: reloads to CLK_DIV-1 on load and raises tc while
// the count sits at zero, so each FSM state lasts exactly CLK_DIV cycles.
module oled_clk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tc
);

  localparam int CNT_W = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/oled_spi_write.sv
// Byte-level 4-wire SPI transmitter for the OLED panel (MSB first, SCLK idle low).
// Define OLED_SPI_CS_HOLD_EN to let DATA[9] keep CS low across multi-byte bursts.
module oled_spi_write
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   WRITE_START,
  input  logic [OLED_WORD_W-1:0] DATA,
  output logic                   WRITE_DONE,
  output logic                   BUSY,
  output logic                   OLED_CS,
  output logic                   OLED_DC,
  output logic                   OLED_SCLK,
  output logic                   OLED_SDIN
);

  oled_state_e state_q, state_d;
  logic [OLED_BYTE_MSB-1:0] sr_q, sr_d;
  logic [2:0] bit_q, bit_d;
  logic cs_q, cs_d;
  logic dc_q, dc_d;
  logic sclk_q, sclk_d;
  logic sdin_q, sdin_d;
  logic done_q, done_d;
  logic busy_q, busy_d;
  logic tick_load, tick_tc;

`ifdef OLED_SPI_CS_HOLD_EN
  logic hold_q, hold_d;
`else
  logic unused_hold;
  assign unused_hold = DATA[OLED_HOLD_BIT];
`endif

  oled_clk_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (CLK),
    .rst_n(RST_N),
    .load (tick_load),
    .tc   (tick_tc)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    cs_d    = cs_q;
    dc_d    = dc_q;
    sclk_d  = sclk_q;
    sdin_d  = sdin_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
`ifdef OLED_SPI_CS_HOLD_EN
    hold_d  = hold_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (WRITE_START) begin
          sr_d    = DATA[OLED_BYTE_MSB-1:0];
          sdin_d  = DATA[OLED_BYTE_MSB];
          dc_d    = DATA[OLED_DC_BIT];
          cs_d    = 1'b0;
          bit_d   = 3'd7;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
`ifdef OLED_SPI_CS_HOLD_EN
          hold_d  = DATA[OLED_HOLD_BIT];
`endif
        end
      end
      ST_SETUP: begin
        if (tick_tc) begin
          sclk_d  = 1'b1;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (tick_tc) begin
          sclk_d = 1'b0;
          if (bit_q == 3'd0) begin
            state_d = ST_HOLD;
          end else begin
            // next bit goes out on the falling edge, giving a full half-period of hold
            sdin_d  = sr_q[OLED_BYTE_MSB-1];
            sr_d    = {sr_q[OLED_BYTE_MSB-2:0], 1'b0};
            bit_d   = bit_q - 3'd1;
            state_d = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        if (tick_tc) begin
          sclk_d  = 1'b1;
          state_d = ST_HIGH;
        end
      end
      ST_HOLD: begin
        if (tick_tc) begin
`ifdef OLED_SPI_CS_HOLD_EN
          cs_d    = ~hold_q;
`else
          cs_d    = 1'b1;
`endif
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // every state change restarts the half-period count
  assign tick_load = (state_d != state_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      bit_q   <= 3'd0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
      sclk_q  <= 1'b0;
      sdin_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef OLED_SPI_CS_HOLD_EN
      hold_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      cs_q    <= cs_d;
      dc_q    <= dc_d;
      sclk_q  <= sclk_d;
      sdin_q  <= sdin_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef OLED_SPI_CS_HOLD_EN
      hold_q  <= hold_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    sr_q <= sr_d;
  end

  assign WRITE_DONE = done_q;
  assign BUSY       = busy_q;
  assign OLED_CS    = cs_q;
  assign OLED_DC    = dc_q;
  assign OLED_SCLK  = sclk_q;
  assign OLED_SDIN  = sdin_q;

endmodule

// File: tb/tb_oled_spi_write.sv
// Directed bench for oled_spi_write: CLK_DIV=4 main instance plus a CLK_DIV=1
// instance for the minimum-divider latency; edge 1 is the edge that samples WRITE_START.
module tb_oled_spi_write;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start1;
  logic [9:0] data, data1;
  logic       done, busy, cs, dc, sclk, sdin;
  logic       done1, busy1, cs1, dc1, sclk1, sdin1;

  always #5 clk = ~clk;

  oled_spi_write #(.CLK_DIV(4)) u_dut (
    .CLK(clk), .RST_N(rst_n), .WRITE_START(start), .DATA(data),
    .WRITE_DONE(done), .BUSY(busy), .OLED_CS(cs), .OLED_DC(dc),
    .OLED_SCLK(sclk), .OLED_SDIN(sdin)
  );

  oled_spi_write #(.CLK_DIV(1)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .WRITE_START(start1), .DATA(data1),
    .WRITE_DONE(done1), .BUSY(busy1), .OLED_CS(cs1), .OLED_DC(dc1),
    .OLED_SCLK(sclk1), .OLED_SDIN(sdin1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt++;

  // serial-line monitors sampled on the falling system edge
  logic        sclk_prev = 1'b0, cs_prev = 1'b1, sclk1_prev = 1'b0;
  int          rise_cnt = 0, done_cnt = 0, dc_hi_rises = 0, cs_rise_cnt = 0;
  int          rise1_cnt = 0;
  logic [15:0] cap = '0, cap1 = '0;

  always @(negedge clk) begin
    if (sclk === 1'b1 && sclk_prev === 1'b0) begin
      rise_cnt++;
      cap = {cap[14:0], sdin};
      if (dc === 1'b1) dc_hi_rises++;
    end
    if (done === 1'b1) done_cnt++;
    if (cs === 1'b1 && cs_prev === 1'b0) cs_rise_cnt++;
    sclk_prev = sclk;
    cs_prev   = cs;
    if (sclk1 === 1'b1 && sclk1_prev === 1'b0) begin
      rise1_cnt++;
      cap1 = {cap1[14:0], sdin1};
    end
    sclk1_prev = sclk1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    rise_cnt = 0; done_cnt = 0; dc_hi_rises = 0; cs_rise_cnt = 0; cap = '0;
    cs_prev = cs;
    rise1_cnt = 0; cap1 = '0;
  endtask

  task automatic start_word(input logic [9:0] w, output int s);
    data  = w;
    start = 1'b1;
    @(posedge clk);
    #1 s = edge_cnt;
    @(negedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int s, output int lat);
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      if (done === 1'b1) begin
        lat = edge_cnt - s + 1;
        break;
      end
      tick(1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1);
  end

  initial begin
    int s, s2, lat, lat2;
    rst_n = 1'b0; start = 1'b0; data = '0; start1 = 1'b0; data1 = '0;
    tick(3);
    check("rst_cs",   cs,   1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_sdin", sdin, 1'b0);
    check("rst_dc",   dc,   1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);

    rst_n = 1'b1;
    clear_mon();
    tick(100);
    check("idle_rises", rise_cnt, 0);
    check("idle_cs",    cs,       1'b1);
    check("idle_busy",  busy,     1'b0);

    // command 0xAE
    clear_mon();
    start_word(10'h0AE, s);
    check("ae_busy", busy, 1'b1);
    check("ae_cs_low", cs, 1'b0);
    wait_done(s, lat);
    check("ae_latency", lat, 69);
    check("ae_busy_done", busy, 1'b0);
    check("ae_rises", rise_cnt, 8);
    check("ae_byte", cap[7:0], 8'hAE);
    check("ae_dc_rises", dc_hi_rises, 0);
    tick(1);
    check("ae_cs_high", cs, 1'b1);
    check("ae_done_cnt", done_cnt, 1);

    // back-to-back display data 0xA5, 0x5A
    clear_mon();
    start_word(10'h1A5, s);
    wait_done(s, lat);
    check("b2b_lat1", lat, 69);
    start_word(10'h15A, s2);
    wait_done(s2, lat2);
    check("b2b_lat2", lat2, 69);
    check("b2b_rises", rise_cnt, 16);
    check("b2b_bytes", cap, 16'hA55A);
    check("b2b_dc_rises", dc_hi_rises, 16);
    check("b2b_done_cnt", done_cnt, 2);
    tick(1);
    check("b2b_dc_hold", dc, 1'b1);

    // request and DATA change while busy
    clear_mon();
    start_word(10'h0C3, s);
    tick(20);
    data = 10'h13C; start = 1'b1;
    tick(1);
    start = 1'b0; data = 10'h3FF;
    wait_done(s, lat);
    check("mid_latency", lat, 69);
    check("mid_byte", cap[7:0], 8'hC3);
    check("mid_dc_rises", dc_hi_rises, 0);
    tick(20);
    check("mid_done_cnt", done_cnt, 1);
    check("mid_rises", rise_cnt, 8);

    // abort by reset after the third SCLK rise
    clear_mon();
    start_word(10'h0AE, s);
    for (int k = 0; k < 100 && rise_cnt < 3; k++) tick(1);
    check("abort_rises", rise_cnt, 3);
    rst_n = 1'b0;
    #1;
    check("abort_cs",   cs,   1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_busy", busy, 1'b0);
    tick(3);
    check("abort_no_done", done_cnt, 0);
    rst_n = 1'b1;
    tick(2);
    clear_mon();
    start_word(10'h0AF, s);
    wait_done(s, lat);
    check("af_latency", lat, 69);
    check("af_byte", cap[7:0], 8'hAF);
    check("af_rises", rise_cnt, 8);
    tick(1);

    // minimum divider
    clear_mon();
    data1 = 10'h0AE; start1 = 1'b1;
    @(posedge clk);
    #1 s = edge_cnt;
    @(negedge clk);
    #1 start1 = 1'b0;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (done1 === 1'b1) begin
        lat = edge_cnt - s + 1;
        break;
      end
      tick(1);
    end
    check("div1_latency", lat, 18);
    check("div1_rises", rise1_cnt, 8);
    check("div1_byte", cap1[7:0], 8'hAE);
    tick(2);

`ifdef OLED_SPI_CS_HOLD_EN
    clear_mon();
    start_word(10'h281, s);
    wait_done(s, lat);
    tick(1);
    check("hold_cs_low1", cs, 1'b0);
    tick(5);
    check("hold_cs_low2", cs, 1'b0);
    start_word(10'h07F, s);
    wait_done(s, lat);
    tick(1);
    check("hold_cs_high", cs, 1'b1);
    check("hold_cs_rises", cs_rise_cnt, 1);
    check("hold_bytes", cap, 16'h817F);
`else
    clear_mon();
    start_word(10'h281, s);
    wait_done(s, lat);
    tick(1);
    check("nohold_cs_high", cs, 1'b1);
    check("nohold_byte", cap[7:0], 8'h81);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/oled_spi_write.md
# oled_spi_write

Byte-level 4-wire SPI transmitter for the SSD1306-class OLED panel. It sits directly downstream of the OLED initialisation and display-refresh sequencers. It accepts one 10-bit command/data word per `WRITE_START`/`WRITE_DONE` handshake and serialises it onto `OLED_SCLK`/`OLED_SDIN`, driving `OLED_CS` and `OLED_DC` accordingly. The block is the only owner of the panel serial pins; `RST_OLED` stays with the init sequencer.

## Interface
Parameters:
- `CLK_DIV`, default 4: `CLK` cycles per SCLK half-period; legal range 1..255.

Ports:
- `CLK` input 1: system clock; one clock domain.
- `RST_N` input 1: reset; asynchronous, active-low.
- `WRITE_START` input 1: request; sampled only when idle.
- `DATA` input 10: `[7:0]` byte, MSB sent first; `[8]` DC (1 = display data, 0 = command); `[9]` CS hold (see Configuration).
- `WRITE_DONE` output 1: one-cycle pulse at the end of each byte.
- `BUSY` output 1: high from accept until the `WRITE_DONE` cycle, exclusive of that cycle.
- `OLED_CS` output 1: chip select, active-low.
- `OLED_DC` output 1: data/command select.
- `OLED_SCLK` output 1: serial clock; idles low.
- `OLED_SDIN` output 1: serial data.

## Operation
- States: IDLE, SETUP, HIGH, LOW, HOLD.
- IDLE, when `WRITE_START` is 1:
  - Latch `DATA` into the shift register.
  - Drive `OLED_CS`=0, `OLED_DC`=`DATA[8]`, `OLED_SDIN`=`DATA[7]`.
  - Set the bit counter to 7, set `BUSY`=1, go to SETUP.
- SETUP (CLK_DIV cycles) → HIGH. `OLED_SCLK` stays 0; this is the data setup time before the first rising edge.
- HIGH (CLK_DIV cycles): `OLED_SCLK`=1; the panel samples on this rising edge. On exit:
  - If bit counter = 0, go to HOLD.
  - Otherwise go to LOW, decrement the counter, and shift the next bit onto `OLED_SDIN`.
- LOW (CLK_DIV cycles): `OLED_SCLK`=0 → HIGH.
- HOLD (CLK_DIV cycles): `OLED_SCLK`=0 → IDLE. On this transition:
  - `OLED_CS`=1 unless hold is in effect.
  - `WRITE_DONE`=1 for exactly one cycle.
  - `BUSY`=0.
- `DATA` is captured only at accept; later changes on `DATA` have no effect on the byte in flight.
- `WRITE_START` while `BUSY`=1 is ignored: no queueing and no error.
- `WRITE_START` in the `WRITE_DONE` cycle is accepted, so back-to-back bytes are allowed.
- `OLED_DC` holds its last value between bytes.
- Half-period counter width is `$clog2(CLK_DIV+1)`. The counter reloads to CLK_DIV-1 on every state entry, and the state advances when it reaches 0.

## Timing
- Reset values:
  - `OLED_CS`=1, `OLED_SCLK`=0, `OLED_SDIN`=0, `OLED_DC`=0.
  - `WRITE_DONE`=0, `BUSY`=0; state IDLE.
- Reset asserted mid-byte aborts the byte immediately and asynchronously: CS rises with no `WRITE_DONE`. After release the block is in IDLE.
- All outputs are registered.
- Latency: `WRITE_DONE` is high in the cycle that begins 17·CLK_DIV+1 rising edges after the edge that sampled `WRITE_START`. For CLK_DIV=4 that is 69 edges.
- SCLK period is 2·CLK_DIV cycles. There are exactly 8 rising edges per byte.
- `OLED_SDIN` changes only on the cycle where SCLK falls, or at accept. This gives ≥ CLK_DIV cycles of setup and of hold.
- `OLED_DC` is stable from accept until the next accept.

## Configuration
- `OLED_SPI_CS_HOLD_EN` defined:
  - `DATA[9]`=1 keeps `OLED_CS` low after HOLD, for multi-byte bursts such as command plus argument.
  - `DATA[9]`=0 releases CS at HOLD.
  - If CS is still low at the next accept, it stays low: no high glitch.
- Not defined: `DATA[9]` is ignored and `OLED_CS` always returns to 1 at HOLD exit.

## Structure
- Shared package `oled_pkg`:
  - State enum.
  - `DATA` field positions: `OLED_DC_BIT`=8, `OLED_HOLD_BIT`=9, byte `[7:0]`.
  - Word width constant 10.
- One sub-module, `oled_clk_tick`: the parameterised half-period down-counter. It reloads on state entry and emits a terminal-count strobe.
- The FSM, shift register and bit counter stay in `oled_spi_write`.

## Test plan
- Reset with `RST_N`=0 → all outputs at their reset values. Release, then hold idle for 100 cycles → no SCLK activity and CS=1.
- CLK_DIV=4, `DATA`=0x0AE (command 0xAE) →
  - SDIN bits 1,0,1,0,1,1,1,0 on 8 SCLK rises.
  - DC=0 throughout.
  - `WRITE_DONE` at edge 69.
  - CS high after the byte.
- `DATA`=0x1A5 followed immediately by 0x15A, with `WRITE_START` in the `WRITE_DONE` cycle →
  - Two bytes with DC=1: 0xA5 then 0x5A.
  - Exactly 16 rising edges.
  - Second `WRITE_DONE` 69 edges after the second accept.
- `WRITE_START` pulsed mid-byte, with `DATA` changed mid-byte → the in-flight byte is unchanged and only one `WRITE_DONE` occurs.
- `RST_N` dropped after the 3rd SCLK rise → CS=1 and SCLK=0 asynchronously, no `WRITE_DONE`. A fresh 0x0AF then sends correctly.
- With `OLED_SPI_CS_HOLD_EN`, send 0x281 then 0x07F → CS stays low between the bytes and rises after the second. Also repeat the 0x0AE case at CLK_DIV=1 → `WRITE_DONE` at edge 18.
